// File: rtl/pulse_regen.sv
// Strobe-to-pulse regenerator: each accepted strobe yields one HIGH_CYC-high, LOW_CYC-low pulse.
// Strobes arriving while busy are held in a saturating pending counter.
module pulse_regen #(
    parameter int unsigned HIGH_CYC = 4,
    parameter int unsigned LOW_CYC  = 4,
    parameter int unsigned PEND_W   = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pulse_in_i,
    input  logic              clr_ovf_i,
    output logic              out_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pending_o,
    output logic              ovf_o
);

    localparam int unsigned MaxCyc = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
    localparam logic [TimerW-1:0] HighLast = TimerW'(HIGH_CYC - 1);
    localparam logic [TimerW-1:0] LowLast  = TimerW'(LOW_CYC - 1);
    localparam logic [PEND_W-1:0] PendMax  = '1;

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic                out_q, out_d;
    logic                busy_q, busy_d;

    logic work;
    logic start;
    logic deq;
    logic enq;
    logic ovf_set;

    assign work = (pend_q != '0) || pulse_in_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            timer_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        start   = 1'b0;
        case (state_q)
            StIdle: begin
                if (work) begin
                    state_d = StHigh;
                    timer_d = '0;
                    start   = 1'b1;
                end
            end
            StHigh: begin
                if (timer_q == HighLast) begin
                    state_d = StLow;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StLow: begin
                if (timer_q == LowLast) begin
                    timer_d = '0;
                    // Back-to-back restart keeps the period at exactly HIGH_CYC+LOW_CYC.
                    if (work) begin
                        state_d = StHigh;
                        start   = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    // A start with an empty queue consumes the live strobe directly; otherwise it takes a queued one.
    always_comb begin
        deq     = start && (pend_q != '0);
        enq     = pulse_in_i && !(start && (pend_q == '0));
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (enq && !deq) begin
            if (pend_q == PendMax) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (deq && !enq) begin
            pend_d = pend_q - PEND_W'(1);
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_comb begin
        out_d  = (state_d == StHigh);
        busy_d = (state_d != StIdle);
    end

    assign out_o     = out_q;
    assign busy_o    = busy_q;
    assign pending_o = pend_q;
    assign ovf_o     = ovf_q;

endmodule
